// File: rtl/fragment_walker.sv
`default_nettype none
// ============================================================================
//  Module   : fragment_walker
//  Purpose  : Walks the inclusive bounding box of one triangle in row-major
//             order, one pixel per cycle, using incremental edge functions.
//             Pixels whose three edge values are non-negative are emitted as
//             fragments (pixel-centre px/py plus the triangle's plane data)
//             through a single valid/ready output register.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                  clock, synchronous active-high reset
//    tri_valid / tri_ready     triangle descriptor handshake
//    xmin,xmax,ymin,ymax       inclusive bounding box (unsigned, XW bits)
//    e_start, e_dx, e_dy       three IW-bit edge values / increments, E0 in LSBs
//    plane_in                  6*IW opaque plane coefficients
//    frag_valid / frag_ready   fragment output handshake
//    px, py                    pixel-centre coordinates, FW fraction bits
//    plane_out                 plane_in captured with the fragment's triangle
//    tri_done                  one-cycle pulse when a triangle walk ends
// ============================================================================
module fragment_walker #(
    parameter int IW = 32,
    parameter int XW = 12,
    parameter int FW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tri_valid,
    output logic              tri_ready,
    input  logic [XW-1:0]     xmin,
    input  logic [XW-1:0]     xmax,
    input  logic [XW-1:0]     ymin,
    input  logic [XW-1:0]     ymax,
    input  logic [3*IW-1:0]   e_start,
    input  logic [3*IW-1:0]   e_dx,
    input  logic [3*IW-1:0]   e_dy,
    input  logic [6*IW-1:0]   plane_in,
    output logic              frag_valid,
    input  logic              frag_ready,
    output logic [IW-1:0]     px,
    output logic [IW-1:0]     py,
    output logic [6*IW-1:0]   plane_out,
    output logic              tri_done
);

    // Half-pixel offset that places px/py on the pixel centre.
    localparam logic [IW-1:0] c_HALF = {{(IW-1){1'b0}}, 1'b1} << (FW-1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_t;

    state_t              r_state_q,      w_state_d;
    logic [XW-1:0]       r_x_q,          w_x_d;
    logic [XW-1:0]       r_y_q,          w_y_d;
    logic [XW-1:0]       r_xmin_q,       w_xmin_d;
    logic [XW-1:0]       r_xmax_q,       w_xmax_d;
    logic [XW-1:0]       r_ymax_q,       w_ymax_d;
    logic                r_empty_q,      w_empty_d;
    logic [2:0][IW-1:0]  r_row_q,        w_row_d;
    logic [2:0][IW-1:0]  r_cur_q,        w_cur_d;
    logic [2:0][IW-1:0]  r_dx_q,         w_dx_d;
    logic [2:0][IW-1:0]  r_dy_q,         w_dy_d;
    logic [6*IW-1:0]     r_plane_q,      w_plane_d;
    logic                r_frag_valid_q, w_frag_valid_d;
    logic [IW-1:0]       r_px_q,         w_px_d;
    logic [IW-1:0]       r_py_q,         w_py_d;
    logic [6*IW-1:0]     r_plane_out_q,  w_plane_out_d;

    logic                w_advance;
    logic                w_covered;
    logic                w_last_x;
    logic                w_last;
    logic [IW-1:0]       w_px_val;
    logic [IW-1:0]       w_py_val;

    always_comb begin
        w_state_d      = r_state_q;
        w_x_d          = r_x_q;
        w_y_d          = r_y_q;
        w_xmin_d       = r_xmin_q;
        w_xmax_d       = r_xmax_q;
        w_ymax_d       = r_ymax_q;
        w_empty_d      = r_empty_q;
        w_row_d        = r_row_q;
        w_cur_d        = r_cur_q;
        w_dx_d         = r_dx_q;
        w_dy_d         = r_dy_q;
        w_plane_d      = r_plane_q;
        w_frag_valid_d = r_frag_valid_q;
        w_px_d         = r_px_q;
        w_py_d         = r_py_q;
        w_plane_out_d  = r_plane_out_q;

        w_covered = !r_cur_q[0][IW-1] && !r_cur_q[1][IW-1] && !r_cur_q[2][IW-1];
        // A pixel is evaluated only when the output register can take a result.
        w_advance = (r_state_q == ST_WALK) && !r_empty_q
                    && (!r_frag_valid_q || frag_ready);
        w_last_x  = (r_x_q == r_xmax_q);
        w_last    = w_last_x && (r_y_q == r_ymax_q);
        w_px_val  = ({{(IW-XW){1'b0}}, r_x_q} << FW) | c_HALF;
        w_py_val  = ({{(IW-XW){1'b0}}, r_y_q} << FW) | c_HALF;

        // tri_done coincides with the evaluation of the last pixel; an empty
        // box spends a single WALK cycle that only raises tri_done.
        tri_done  = (r_state_q == ST_WALK) && (r_empty_q || (w_advance && w_last));

        case (r_state_q)
            ST_IDLE: begin
                if (tri_valid) begin
                    w_x_d     = xmin;
                    w_y_d     = ymin;
                    w_xmin_d  = xmin;
                    w_xmax_d  = xmax;
                    w_ymax_d  = ymax;
                    w_empty_d = (xmin > xmax) || (ymin > ymax);
                    w_row_d   = e_start;
                    w_cur_d   = e_start;
                    w_dx_d    = e_dx;
                    w_dy_d    = e_dy;
                    w_plane_d = plane_in;
                    w_state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (r_empty_q) begin
                    w_state_d = ST_IDLE;
                end else if (w_advance) begin
                    if (w_last) begin
                        w_state_d = ST_IDLE;
                    end else if (w_last_x) begin
                        w_x_d = r_xmin_q;
                        w_y_d = r_y_q + 1'b1;
                        for (int k = 0; k < 3; k++) begin
                            w_row_d[k] = r_row_q[k] + r_dy_q[k];
                            w_cur_d[k] = r_row_q[k] + r_dy_q[k];
                        end
                    end else begin
                        w_x_d = r_x_q + 1'b1;
                        for (int k = 0; k < 3; k++) begin
                            w_cur_d[k] = r_cur_q[k] + r_dx_q[k];
                        end
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Output register: load on a covered evaluated pixel; otherwise drop
        // valid only once the held fragment has been accepted.
        if (w_advance) begin
            w_frag_valid_d = w_covered;
            if (w_covered) begin
                w_px_d        = w_px_val;
                w_py_d        = w_py_val;
                w_plane_out_d = r_plane_q;
            end
        end else if (frag_ready) begin
            w_frag_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_x_q          <= '0;
            r_y_q          <= '0;
            r_xmin_q       <= '0;
            r_xmax_q       <= '0;
            r_ymax_q       <= '0;
            r_empty_q      <= 1'b0;
            r_row_q        <= '0;
            r_cur_q        <= '0;
            r_dx_q         <= '0;
            r_dy_q         <= '0;
            r_plane_q      <= '0;
            r_frag_valid_q <= 1'b0;
            r_px_q         <= '0;
            r_py_q         <= '0;
            r_plane_out_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_x_q          <= w_x_d;
            r_y_q          <= w_y_d;
            r_xmin_q       <= w_xmin_d;
            r_xmax_q       <= w_xmax_d;
            r_ymax_q       <= w_ymax_d;
            r_empty_q      <= w_empty_d;
            r_row_q        <= w_row_d;
            r_cur_q        <= w_cur_d;
            r_dx_q         <= w_dx_d;
            r_dy_q         <= w_dy_d;
            r_plane_q      <= w_plane_d;
            r_frag_valid_q <= w_frag_valid_d;
            r_px_q         <= w_px_d;
            r_py_q         <= w_py_d;
            r_plane_out_q  <= w_plane_out_d;
        end
    end

    assign tri_ready  = (r_state_q == ST_IDLE);
    assign frag_valid = r_frag_valid_q;
    assign px         = r_px_q;
    assign py         = r_py_q;
    assign plane_out  = r_plane_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fragment_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fragment_walker
//  Purpose  : Self-checking bench for fragment_walker. Directed triangles push
//             hand-computed fragments into a scoreboard queue; a monitor pops
//             and compares every accepted fragment.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fragment_walker;

    localparam int IW = 32;
    localparam int XW = 12;
    localparam int FW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              tri_valid;
    logic              tri_ready;
    logic [XW-1:0]     xmin, xmax, ymin, ymax;
    logic [3*IW-1:0]   e_start, e_dx, e_dy;
    logic [6*IW-1:0]   plane_in;
    logic              frag_valid;
    logic              frag_ready;
    logic [IW-1:0]     px, py;
    logic [6*IW-1:0]   plane_out;
    logic              tri_done;

    fragment_walker #(.IW(IW), .XW(XW), .FW(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .xmin       (xmin),
        .xmax       (xmax),
        .ymin       (ymin),
        .ymax       (ymax),
        .e_start    (e_start),
        .e_dx       (e_dx),
        .e_dy       (e_dy),
        .plane_in   (plane_in),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .px         (px),
        .py         (py),
        .plane_out  (plane_out),
        .tri_done   (tri_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0]   px;
        logic [IW-1:0]   py;
        logic [6*IW-1:0] plane;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_exp;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_frag   = 0;

    localparam logic [6*IW-1:0] PA = {6{32'hA5A5_0001}};
    localparam logic [6*IW-1:0] PB = {6{32'hB0B0_0002}};
    localparam logic [6*IW-1:0] PC = {6{32'hC3C3_0003}};
    localparam logic [6*IW-1:0] PE = {6{32'hE1E1_0004}};
    localparam logic [6*IW-1:0] P1 = {6{32'h1234_5678}};
    localparam logic [6*IW-1:0] P2 = {6{32'h8765_4321}};
    localparam logic [6*IW-1:0] PG = {6{32'h6060_0007}};
    localparam logic [IW-1:0]   NEG1 = 32'hFFFF_FFFF;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [IW-1:0] ex, input logic [IW-1:0] ey, input logic [6*IW-1:0] pl);
        exp_t e;
        e.px = ex; e.py = ey; e.plane = pl;
        sb_q.push_back(e);
    endtask

    // Monitor: every accepted fragment must match the head of the scoreboard.
    always @(negedge clk) begin
        if (tri_done) n_done++;
        if (!rst && frag_valid && frag_ready) begin
            n_frag++;
            if (sb_q.size() == 0) begin
                check("unexpected_frag", {px, py}, 0);
            end else begin
                m_exp = sb_q.pop_front();
                check("frag_px", px, m_exp.px);
                check("frag_py", py, m_exp.py);
                check("frag_plane", plane_out, m_exp.plane);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [XW-1:0] x0, input logic [XW-1:0] x1,
                        input logic [XW-1:0] y0, input logic [XW-1:0] y1,
                        input logic [3*IW-1:0] es, input logic [3*IW-1:0] dx,
                        input logic [3*IW-1:0] dy, input logic [6*IW-1:0] pl);
        int waited;
        xmin = x0; xmax = x1; ymin = y0; ymax = y1;
        e_start = es; e_dx = dx; e_dy = dy; plane_in = pl;
        tri_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!tri_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!tri_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        tri_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((sb_q.size() != 0 || !tri_ready) && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Observes tri_done for a few cycles after acceptance.
    task automatic watch_done(input string name, input int exp_cycle);
        int first;
        int cnt;
        first = 0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) check({name, "_fv_T1"}, frag_valid, 0);
            if (tri_done) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        check({name, "_done_cycle"}, first, exp_cycle);
        check({name, "_done_pulses"}, cnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int done_before;
        int k;
        rst = 1'b1; tri_valid = 1'b0; frag_ready = 1'b1;
        xmin = '0; xmax = '0; ymin = '0; ymax = '0;
        e_start = '0; e_dx = '0; e_dy = '0; plane_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tri_ready", tri_ready, 1);
        check("rst_frag_valid", frag_valid, 0);
        check("rst_tri_done", tri_done, 0);
        check("rst_px_py", {px, py}, 0);
        check("rst_plane", plane_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2x2 box, fully covered
        push(32'h8000, 32'h8000, PA);
        push(32'h18000, 32'h8000, PA);
        push(32'h8000, 32'h18000, PA);
        push(32'h18000, 32'h18000, PA);
        send(0, 1, 0, 1, {3{32'd10}}, '0, '0, PA);
        watch_done("A", 4);
        wait_drain();

        // 4x1 row, only the first pixel covered by E0
        push(32'h8000, 32'h8000, PB);
        send(0, 3, 0, 0, {32'd10, 32'd10, 32'd0}, {32'd0, 32'd0, NEG1}, '0, PB);
        watch_done("B", 4);
        wait_drain();

        // 2x2 box with 5 cycles of backpressure on the first fragment
        push(32'h8000, 32'h8000, PC);
        push(32'h18000, 32'h8000, PC);
        push(32'h8000, 32'h18000, PC);
        push(32'h18000, 32'h18000, PC);
        frag_ready = 1'b0;
        send(0, 1, 0, 1, {3{32'd10}}, '0, '0, PC);
        k = 0;
        @(negedge clk);
        while (!frag_valid && k < 10) begin
            k++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("C_stall_valid", frag_valid, 1);
            check("C_stall_pxpy", {px, py}, {32'h8000, 32'h8000});
            check("C_stall_plane", plane_out, PC);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        frag_ready = 1'b1;
        wait_drain();

        // Empty box: xmin > xmax
        send(5, 4, 0, 0, {3{32'd10}}, '0, '0, PA);
        @(negedge clk);
        check("D_tri_ready_low", tri_ready, 0);
        check("D_tri_done", tri_done, 1);
        @(negedge clk);
        check("D_tri_ready_back", tri_ready, 1);
        check("D_tri_done_end", tri_done, 0);
        wait_drain();

        // Reset mid-walk
        done_before = n_done;
        frag_ready = 1'b0;
        send(0, 1, 0, 1, {3{32'd10}}, '0, '0, PE);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("E_tri_ready", tri_ready, 1);
            check("E_frag_valid", frag_valid, 0);
            check("E_tri_done", tri_done, 0);
        end
        check("E_no_done", n_done, done_before);
        frag_ready = 1'b1;
        wait_drain();

        // Two single-pixel triangles back-to-back
        push(32'h38000, 32'h28000, P1);
        push(32'h78000, 32'h18000, P2);
        send(3, 3, 2, 2, {3{32'd5}}, '0, '0, P1);
        send(7, 7, 1, 1, {3{32'd5}}, '0, '0, P2);
        wait_drain();

        // 2x2 box with a sloped edge: exercises row reload via e_dy
        push(32'h8000, 32'h8000, PG);
        push(32'h8000, 32'h18000, PG);
        push(32'h18000, 32'h18000, PG);
        send(0, 1, 0, 1, {32'd10, 32'd10, 32'd0}, {32'd0, 32'd0, NEG1},
             {32'd0, 32'd0, 32'd1}, PG);
        wait_drain();

        repeat (4) @(negedge clk);
        check("total_frags", n_frag, 14);
        check("total_done", n_done, 7);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
